// File: rtl/ir_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ir_sequencer_pkg
//   Shared types and constants for the 16-bit CPU control path: instruction
//   opcodes, ALU function selects, decoded instruction classes and the
//   fetch/decode/execute sequencer states.
// ---------------------------------------------------------------------------
package ir_sequencer_pkg;

    localparam int unsigned CPU_DATA_WIDTH  = 16;
    localparam int unsigned CPU_ALU_OPCODE  = 4;
    localparam int unsigned OPC_W           = CPU_ALU_OPCODE + 1;
    localparam int unsigned CPU_ALU_SEL_W   = 3;
    localparam int unsigned CPU_MEM_TIMEOUT = 15;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 5'b00000,
        OP_LDA = 5'b00001,
        OP_STA = 5'b00010,
        OP_ADD = 5'b00011,
        OP_SUB = 5'b00100,
        OP_AND = 5'b00101,
        OP_OR  = 5'b00110,
        OP_XOR = 5'b00111,
        OP_JMP = 5'b01000,
        OP_JZ  = 5'b01001,
        OP_HLT = 5'b11111
    } opcode_t;

    typedef enum logic [CPU_ALU_SEL_W-1:0] {
        ALU_PASS_B = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_AND    = 3'd3,
        ALU_OR     = 3'd4,
        ALU_XOR    = 3'd5
    } alu_sel_t;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_RD,
        CL_WR,
        CL_JMP,
        CL_JZ,
        CL_HLT,
        CL_ILL
    } op_class_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_RD,
        S_EXEC_WR,
        S_HALT
    } seq_state_t;

endpackage

// File: rtl/ir_sequencer_opcode_decoder.sv
// ---------------------------------------------------------------------------
// opcode_decoder
//   Combinational decode of the IR opcode field into an instruction class
//   and the ALU function used during a memory-read execute cycle.
//   opcode_i  in   OPC_W      opcode field from the instruction register
//   class_o   out  op_class_t rd / wr / jmp / jz / hlt / nop / illegal
//   alu_o     out  alu_sel_t  ALU function (PASS_B for non-ALU opcodes)
// ---------------------------------------------------------------------------
module opcode_decoder
    import ir_sequencer_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output op_class_t        class_o,
    output alu_sel_t         alu_o
);

    always_comb begin
        class_o = CL_ILL;
        alu_o   = ALU_PASS_B;
        case (opcode_i)
            OP_NOP: class_o = CL_NOP;
            OP_LDA: class_o = CL_RD;
            OP_STA: class_o = CL_WR;
            OP_ADD: begin class_o = CL_RD; alu_o = ALU_ADD; end
            OP_SUB: begin class_o = CL_RD; alu_o = ALU_SUB; end
            OP_AND: begin class_o = CL_RD; alu_o = ALU_AND; end
            OP_OR:  begin class_o = CL_RD; alu_o = ALU_OR;  end
            OP_XOR: begin class_o = CL_RD; alu_o = ALU_XOR; end
            OP_JMP: class_o = CL_JMP;
            OP_JZ:  class_o = CL_JZ;
            OP_HLT: class_o = CL_HLT;
            default: class_o = CL_ILL;
        endcase
    end

endmodule

// File: rtl/ir_sequencer.sv
// ---------------------------------------------------------------------------
// ir_sequencer
//   Fetch/decode/execute controller for the 16-bit CPU. Sole source of
//   loadIR / loadPC / incPC; drives the memory request port and ALU select.
//   iclk       in   clock (rising edge)
//   irst_n     in   synchronous active-low reset
//   istart     in   pulse: leave IDLE and begin fetching
//   opcode     in   opcode field from the instruction register
//   zero_flag  in   accumulator == 0
//   mem_ack    in   memory handshake complete
//   loadIR     out  load fetched word into IR (qualified by mem_ack)
//   incPC      out  PC <= PC+1 (qualified by mem_ack)
//   loadPC     out  PC <= IR address (JMP, taken JZ)
//   addr_sel   out  0: address = PC, 1: address = IR address
//   mem_req    out  memory request, held until mem_ack
//   mem_we     out  write qualifier for mem_req
//   loadACC    out  ACC <= ALU result (qualified by mem_ack)
//   alu_op     out  ALU function select
//   halted     out  in HALT
//   illegal    out  pulse: undefined opcode decoded
//   bus_err    out  sticky memory-timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module ir_sequencer
    import ir_sequencer_pkg::*;
#(
    parameter int unsigned ALU_OPCODE  = CPU_ALU_OPCODE,
    parameter int unsigned ALU_SEL_W   = CPU_ALU_SEL_W,
    parameter int unsigned MEM_TIMEOUT = CPU_MEM_TIMEOUT
) (
    input  logic                 iclk,
    input  logic                 irst_n,
    input  logic                 istart,
    input  logic [ALU_OPCODE:0]  opcode,
    input  logic                 zero_flag,
    input  logic                 mem_ack,
    output logic                 loadIR,
    output logic                 incPC,
    output logic                 loadPC,
    output logic                 addr_sel,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 loadACC,
    output logic [ALU_SEL_W-1:0] alu_op,
    output logic                 halted,
    output logic                 illegal,
    output logic                 bus_err
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             tmo;
    op_class_t        dec_class;
    alu_sel_t         dec_alu;

    opcode_decoder u_dec (
        .opcode_i (opcode),
        .class_o  (dec_class),
        .alu_o    (dec_alu)
    );

    // Ack in the cycle where the count equals MEM_TIMEOUT still completes;
    // only an unacked cycle at that count raises the bus error.
    assign tmo     = (cnt_q == CNT_W'(MEM_TIMEOUT));
    assign bus_err = bus_err_q;

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // cnt_d defaults to zero so the counter is clear on entry to every
    // request state, including the direct EXEC_* -> FETCH hand-over.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        bus_err_d = bus_err_q;
        loadIR    = 1'b0;
        incPC     = 1'b0;
        loadPC    = 1'b0;
        addr_sel  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        loadACC   = 1'b0;
        alu_op    = '0;
        halted    = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (istart) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    loadIR  = 1'b1;
                    incPC   = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (dec_class)
                    CL_RD:   state_d = S_EXEC_RD;
                    CL_WR:   state_d = S_EXEC_WR;
                    CL_JMP:  loadPC  = 1'b1;
                    CL_JZ:   loadPC  = zero_flag;
                    CL_HLT:  state_d = S_HALT;
                    CL_ILL:  illegal = 1'b1;
                    default: state_d = S_FETCH;
                endcase
            end
            S_EXEC_RD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                alu_op   = ALU_SEL_W'(dec_alu);
                if (mem_ack) begin
                    loadACC = 1'b1;
                    state_d = S_FETCH;
                end else if (tmo) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXEC_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ack) begin
                    state_d = S_FETCH;
                end else if (tmo) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ir_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ir_sequencer
//   Builds a cycle-by-cycle trace of inputs and expected outputs from
//   instruction-level rules (per-instruction phase lengths derived from
//   chosen memory wait counts), then replays it against the sequencer.
// ---------------------------------------------------------------------------
module tb_ir_sequencer;

    localparam int TMO = 15;

    logic       iclk = 1'b0;
    logic       irst_n = 1'b0;
    logic       istart = 1'b0;
    logic [4:0] opcode = '0;
    logic       zero_flag = 1'b0;
    logic       mem_ack = 1'b0;
    logic       loadIR, incPC, loadPC, addr_sel, mem_req, mem_we, loadACC;
    logic [2:0] alu_op;
    logic       halted, illegal, bus_err;

    always #5 iclk = ~iclk;

    ir_sequencer #(.MEM_TIMEOUT(TMO)) dut (
        .iclk      (iclk),
        .irst_n    (irst_n),
        .istart    (istart),
        .opcode    (opcode),
        .zero_flag (zero_flag),
        .mem_ack   (mem_ack),
        .loadIR    (loadIR),
        .incPC     (incPC),
        .loadPC    (loadPC),
        .addr_sel  (addr_sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .loadACC   (loadACC),
        .alu_op    (alu_op),
        .halted    (halted),
        .illegal   (illegal),
        .bus_err   (bus_err)
    );

    typedef struct {
        bit        rst_n;
        bit        st;
        bit        ack;
        bit        zf;
        bit [4:0]  opc;
        bit [12:0] exp;
        bit        chk;
    } cyc_t;

    cyc_t q[$];
    bit   berr = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (lir inc lpc asel req we lacc alu[2:0] hlt ill berr)",
                     tag, obs, exp);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    // Expected output vector; bus_err comes from the running sticky flag.
    function automatic bit [12:0] ov(bit lir, bit inc, bit lpc, bit asel, bit req, bit we,
                                     bit lacc, bit [2:0] alu, bit hlt, bit ill);
        return {lir, inc, lpc, asel, req, we, lacc, alu, hlt, ill, berr};
    endfunction

    // 0 nop, 1 read/alu, 2 write, 3 jmp, 4 jz, 5 halt, 6 illegal
    function automatic int cls_of(bit [4:0] o);
        if (o == 0) return 0;
        if (o == 1 || (o >= 3 && o <= 7)) return 1;
        if (o == 2) return 2;
        if (o == 8) return 3;
        if (o == 9) return 4;
        if (o == 31) return 5;
        return 6;
    endfunction

    function automatic bit [2:0] alu_of(bit [4:0] o);
        if (o >= 3 && o <= 7) return 3'(o - 2);
        return 3'd0;
    endfunction

    task automatic push(input bit rst_n, input bit st, input bit ack, input bit zf,
                        input bit [4:0] opc, input bit [12:0] e, input bit chk = 1'b1);
        cyc_t c;
        c.rst_n = rst_n; c.st = st; c.ack = ack; c.zf = zf;
        c.opc = opc; c.exp = e; c.chk = chk;
        q.push_back(c);
    endtask

    task automatic do_reset(input bit [12:0] cur, input bit chk = 1'b1);
        push(1'b0, rb(), rb(), rb(), 5'($urandom), cur, chk);
        berr = 1'b0;
    endtask

    task automatic start_seq(input int idle_n);
        for (int i = 0; i < idle_n; i++)
            push(1'b1, 1'b0, rb(), rb(), 5'($urandom), ov(0,0,0,0,0,0,0,3'd0,0,0));
        push(1'b1, 1'b1, rb(), rb(), 5'($urandom), ov(0,0,0,0,0,0,0,3'd0,0,0));
    endtask

    task automatic halt_cycles(input int n, input bit force_st);
        for (int i = 0; i < n; i++)
            push(1'b1, force_st ? 1'b1 : rb(), rb(), rb(), 5'($urandom),
                 ov(0,0,0,0,0,0,0,3'd0,1,0));
    endtask

    // One memory phase: kind 0 fetch, 1 exec read, 2 exec write.
    // Ack arrives after w wait cycles; memory may complete within TMO+1 cycles.
    // res: 0 done, 1 timed out (now halted), 2 reset applied (now idle).
    task automatic req_phase(input bit [4:0] opc, input bit zf, input int kind, input int w,
                             input int rst_at, output int res);
        bit [2:0] alu = (kind == 1) ? alu_of(opc) : 3'd0;
        bit ack;
        for (int k = 0; k <= w && k <= TMO; k++) begin
            ack = (k == w);
            if (k == rst_at) begin
                push(1'b0, 1'b0, 1'b0, zf, opc, ov(0,0,0, kind != 0, 1, kind == 2, 0, alu, 0, 0));
                berr = 1'b0;
                res = 2;
                return;
            end
            push(1'b1, rb(), ack, zf, opc,
                 ov(kind == 0 && ack, kind == 0 && ack, 0, kind != 0, 1, kind == 2,
                    kind == 1 && ack, alu, 0, 0));
        end
        if (w > TMO) begin
            berr = 1'b1;
            res = 1;
        end else begin
            res = 0;
        end
    endtask

    task automatic instr(input bit [4:0] opc, input bit zf, input int wf, input int we,
                         input int rst_at, output int res);
        int c = cls_of(opc);
        req_phase(opc, zf, 0, wf, -1, res);
        if (res != 0) return;
        push(1'b1, rb(), rb(), zf, opc,
             ov(0, 0, (c == 3) || (c == 4 && zf), 0, 0, 0, 0, 3'd0, 0, c == 6));
        if (c == 5) begin
            res = 1;
            return;
        end
        if (c == 1 || c == 2)
            req_phase(opc, zf, c, we, rst_at, res);
    endtask

    function automatic bit [4:0] pick_opc();
        int r = int'($urandom % 20);
        if (r < 16) return 5'($urandom % 10);
        if (r < 19) return 5'($urandom_range(10, 30));
        return 5'b11111;
    endfunction

    function automatic int pick_wait();
        int r = int'($urandom % 32);
        if (r < 28) return r % 3;
        if (r < 31) return TMO;
        return TMO + 1;
    endfunction

    task automatic build();
        int res;
        bit done;
        bit [4:0] opc;
        do_reset(13'd0, 1'b0);
        // Zero-wait LDA then ADD, JZ taken/not taken, delayed fetch, illegal,
        // STA, read acked exactly at the timeout count, then HLT under istart.
        start_seq(0);
        instr(5'b00001, 0, 0, 0, -1, res);
        instr(5'b00011, 0, 0, 0, -1, res);
        instr(5'b01001, 1, 0, 0, -1, res);
        instr(5'b01001, 0, 0, 0, -1, res);
        instr(5'b00000, 0, 3, 0, -1, res);
        instr(5'b11000, 1, 0, 0, -1, res);
        instr(5'b00010, 0, 0, 2, -1, res);
        instr(5'b00101, 0, 1, TMO, -1, res);
        instr(5'b11111, 0, 0, 0, -1, res);
        halt_cycles(10, 1'b1);
        do_reset(ov(0,0,0,0,0,0,0,3'd0,1,0));
        // Read never acked: bus error and halt.
        start_seq(2);
        instr(5'b00111, 0, 0, TMO + 1, -1, res);
        halt_cycles(3, 1'b1);
        do_reset(ov(0,0,0,0,0,0,0,3'd0,1,0));
        // Reset in the middle of a write, then recovery.
        start_seq(1);
        instr(5'b00010, 0, 0, 3, 1, res);
        start_seq(1);
        instr(5'b01000, 0, 0, 0, -1, res);
        instr(5'b11111, 0, 0, 0, -1, res);
        halt_cycles(2, 1'b0);
        do_reset(ov(0,0,0,0,0,0,0,3'd0,1,0));
        // Random programs.
        for (int r = 0; r < 60; r++) begin
            start_seq(int'($urandom_range(0, 3)));
            done = 1'b0;
            for (int n = 0; n < 24 && !done; n++) begin
                opc = (n == 23) ? 5'b11111 : pick_opc();
                instr(opc, rb(), pick_wait(), pick_wait(),
                      ($urandom % 16 == 0) ? int'($urandom_range(0, 2)) : -1, res);
                if (res == 2) begin
                    done = 1'b1;
                end else if (res == 1) begin
                    halt_cycles(int'($urandom_range(1, 4)), 1'b0);
                    do_reset(ov(0,0,0,0,0,0,0,3'd0,1,0));
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        cyc_t c;
        int idx = 0;
        build();
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge iclk);
            #1;
            irst_n    = c.rst_n;
            istart    = c.st;
            mem_ack   = c.ack;
            zero_flag = c.zf;
            opcode    = c.opc;
            @(negedge iclk);
            if (c.chk)
                check($sformatf("cyc%0d", idx),
                      {loadIR, incPC, loadPC, addr_sel, mem_req, mem_we, loadACC,
                       alu_op, halted, illegal, bus_err}, c.exp);
            idx++;
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
